reg_file_sb: RTL

//  Parametrised multi-port integer register file with an integrated scoreboard and a sweep-clear engine.

---
 rtl/reg_file_sb.sv | 135 +++++++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// Multi-port integer register file with a busy-bit scoreboard, write-to-read
// bypass and a one-register-per-cycle sweep-clear engine.
module reg_file_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0]     rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en_a,
  input  logic [ADDR_W-1:0]          wr_addr_a,
  input  logic [XLEN-1:0]            wr_data_a,
  input  logic                       wr_en_b,
  input  logic [ADDR_W-1:0]          wr_addr_b,
  input  logic [XLEN-1:0]            wr_data_b,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  input  logic                       flush,
  input  logic                       clear_req,
  output logic                       clear_busy,
  output logic                       clear_done
);

  typedef enum logic [1:0] {ST_IDLE, ST_SWEEP, ST_DONE} state_e;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

  state_e                state_q, state_d;
  logic [ADDR_W:0]       idx_q, idx_d;
  logic [XLEN-1:0]       regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  sweeping;
  logic                  we_a, we_b, issue_ok;

  // External writes and issues are dropped while the sweep owns the storage.
  always_comb begin
    sweeping = (state_q == ST_SWEEP);
    we_a     = wr_en_a  && !sweeping && !((ZERO_REG != 0) && (wr_addr_a  == '0));
    we_b     = wr_en_b  && !sweeping && !((ZERO_REG != 0) && (wr_addr_b  == '0));
    issue_ok = issue_en && !sweeping && !((ZERO_REG != 0) && (issue_addr == '0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clear_req) state_d = ST_SWEEP;
      ST_SWEEP: if (idx_q == LAST_IDX) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (state_q == ST_SWEEP);
    clear_done = (state_q == ST_DONE);
  end

  always_comb begin
    idx_d = sweeping ? idx_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  // Order matters: flush, then write releases, then issue, so a same-cycle
  // issue always leaves its bit set.
  always_comb begin
    busy_d = busy_q;
    if (sweeping) begin
      busy_d[idx_q[ADDR_W-1:0]] = 1'b0;
    end else begin
      if (flush)    busy_d = '0;
      if (we_a)     busy_d[wr_addr_a]  = 1'b0;
      if (we_b)     busy_d[wr_addr_b]  = 1'b0;
      if (issue_ok) busy_d[issue_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // NOTE: the array is reset because the architecture requires zeroed
  // registers after reset; this prevents mapping it onto a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (sweeping) begin
      regs_q[idx_q[ADDR_W-1:0]] <= '0;
    end else begin
      // NOTE: with non-blocking assignments the last one to the same
      // element wins, which gives port B priority over port A.
      if (we_a) regs_q[wr_addr_a] <= wr_data_a;
      if (we_b) regs_q[wr_addr_b] <= wr_data_b;
    end
  end

  // NOTE: every temporary gets a value before use so no latch is inferred.
  always_comb begin
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   data;
    logic              hit_a, hit_b;
    addr    = '0;
    data    = '0;
    hit_a   = 1'b0;
    hit_b   = 1'b0;
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr  = rd_addr[i*ADDR_W +: ADDR_W];
      hit_a = we_a && (wr_addr_a == addr);
      hit_b = we_b && (wr_addr_b == addr);
      data  = regs_q[addr];
      if (hit_a) data = wr_data_a;
      if (hit_b) data = wr_data_b;
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      rd_data[i*XLEN +: XLEN] = data;
      rd_busy[i] = busy_q[addr] & ~(hit_a | hit_b);
    end
  end

endmodule
